// File: rtl/gba_bus_pkg.sv
// Shared definitions for the GBA memory-side bus controller: region codes,
// access widths, FSM states and small data helpers.
package gba_bus_pkg;

  localparam logic [3:0] REG_BIOS  = 4'h0;
  localparam logic [3:0] REG_EWRAM = 4'h2;
  localparam logic [3:0] REG_IWRAM = 4'h3;
  localparam logic [3:0] REG_IO    = 4'h4;
  localparam logic [3:0] REG_PAL   = 4'h5;
  localparam logic [3:0] REG_VRAM  = 4'h6;
  localparam logic [3:0] REG_OAM   = 4'h7;
  localparam logic [3:0] REG_SRAM  = 4'hE;
  localparam logic [3:0] REG_NONE  = 4'hF;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  // Width code 3 behaves as a word access.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'd3) ? W_WORD : w;
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] d, input logic [4:0] sh);
    logic [63:0] t;
    t = {d, d} >> sh;
    return t[31:0];
  endfunction

endpackage

// File: rtl/gba_bus_ctrl_if.sv
// CPU request bus and backing-memory port of the GBA bus controller.
interface gba_bus_ctrl_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_width;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        mem_ok;
  logic        bus_err;
  logic        ext_req;
  logic        ext_we;
  logic [3:0]  ext_region;
  logic [31:0] ext_addr;
  logic [3:0]  ext_be;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_width, cpu_read, cpu_write, ext_rdata, ext_ack,
    output cpu_rdata, mem_ok, bus_err, ext_req, ext_we, ext_region, ext_addr, ext_be, ext_wdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_width, cpu_read, cpu_write, ext_rdata, ext_ack,
    input  cpu_rdata, mem_ok, bus_err, ext_req, ext_we, ext_region, ext_addr, ext_be, ext_wdata
  );
endinterface

// File: rtl/gba_addr_decode.sv
// GBA address map decode: region code, wait states and per-region write rules.
module gba_addr_decode import gba_bus_pkg::*; #(
  parameter int unsigned WS_BIOS  = 0,
  parameter int unsigned WS_EWRAM = 2,
  parameter int unsigned WS_IWRAM = 0,
  parameter int unsigned WS_IO    = 0,
  parameter int unsigned WS_VIDEO = 0,
  parameter int unsigned WS_ROM   = 4,
  parameter int unsigned WS_SRAM  = 4
) (
  input  logic [3:0] addr_hi,
  input  logic [1:0] width,
  input  logic       we,
  output logic [3:0] region,
  output logic [3:0] wait_cnt,
  output logic       write_drop,
  output logic [1:0] eff_width
);

  logic [1:0] nw;
  assign nw = norm_width(width);

  always_comb begin
    region     = addr_hi;
    wait_cnt   = '0;
    write_drop = 1'b0;
    eff_width  = nw;
    case (addr_hi)
      4'h0: begin
        wait_cnt   = 4'(WS_BIOS);
        write_drop = we;
      end
      4'h2: wait_cnt = 4'(WS_EWRAM);
      4'h3: wait_cnt = 4'(WS_IWRAM);
      4'h4: wait_cnt = 4'(WS_IO);
      4'h5, 4'h6: begin
        wait_cnt = 4'(WS_VIDEO);
        // palette/VRAM have no byte strobes: a byte store lands on the whole halfword
        if (we && nw == W_BYTE) eff_width = W_HALF;
      end
      4'h7: begin
        wait_cnt   = 4'(WS_VIDEO);
        write_drop = we && (nw == W_BYTE);
      end
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
        wait_cnt   = 4'(WS_ROM);
        write_drop = we;
      end
      4'hE: begin
        wait_cnt  = 4'(WS_SRAM);
        eff_width = W_BYTE;
      end
      default: region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/gba_bus_ctrl.sv
// Memory-side responder for the CPU request bus: decodes the GBA map, inserts
// wait states, issues one aligned word access and lane-aligns data both ways.
module gba_bus_ctrl import gba_bus_pkg::*; #(
  parameter int unsigned WS_BIOS  = 0,
  parameter int unsigned WS_EWRAM = 2,
  parameter int unsigned WS_IWRAM = 0,
  parameter int unsigned WS_IO    = 0,
  parameter int unsigned WS_VIDEO = 0,
  parameter int unsigned WS_ROM   = 4,
  parameter int unsigned WS_SRAM  = 4
) (
  input logic          clk,
  input logic          rstn,
  gba_bus_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  width_q;
  logic [3:0]  region_q, be_q;
  logic        we_q, drop_q;

  logic        req, we_in, accept;
  logic [3:0]  dec_region, dec_wait;
  logic        dec_drop;
  logic [1:0]  dec_eff, nw;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] lane_src, rd_src, rd_shift, half_src, rd_aligned;
  logic        mem_ok, bus_err, ext_req;

  assign req    = bus.cpu_read | bus.cpu_write;
  assign we_in  = bus.cpu_write & ~bus.cpu_read;
  assign nw     = norm_width(bus.cpu_width);
  assign accept = (state_q == S_IDLE) && req;

  gba_addr_decode #(
    .WS_BIOS (WS_BIOS),  .WS_EWRAM(WS_EWRAM), .WS_IWRAM(WS_IWRAM), .WS_IO(WS_IO),
    .WS_VIDEO(WS_VIDEO), .WS_ROM  (WS_ROM),   .WS_SRAM (WS_SRAM)
  ) u_decode (
    .addr_hi   (bus.cpu_addr[27:24]),
    .width     (bus.cpu_width),
    .we        (we_in),
    .region    (dec_region),
    .wait_cnt  (dec_wait),
    .write_drop(dec_drop),
    .eff_width (dec_eff)
  );

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = bus.cpu_wdata;
    case (dec_eff)
      W_BYTE: begin
        be_in    = 4'b0001 << bus.cpu_addr[1:0];
        wdata_in = {4{bus.cpu_wdata[7:0]}};
      end
      W_HALF: begin
        be_in    = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = (nw == W_BYTE) ? {4{bus.cpu_wdata[7:0]}} : {2{bus.cpu_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!we_in || dec_drop) be_in = 4'b0000;
  end

  // SRAM is an 8-bit device: its byte shows up on every lane of a wider read
  always_comb begin
    lane_src = bus.ext_rdata >> {addr_q[1:0], 3'b000};
    rd_src   = (region_q == REG_SRAM) ? {4{lane_src[7:0]}} : bus.ext_rdata;
    rd_shift = rd_src >> {addr_q[1:0], 3'b000};
    half_src = rd_src >> {addr_q[1], 4'b0000};
    case (width_q)
      W_BYTE:  rd_aligned = {24'h0, rd_shift[7:0]};
      W_HALF:  rd_aligned = addr_q[0] ? ror32({16'h0, half_src[15:0]}, 5'd8)
                                      : {16'h0, half_src[15:0]};
      default: rd_aligned = ror32(rd_src, {addr_q[1:0], 3'b000});
    endcase
  end

  always_comb begin
    state_d = state_q;
    mem_ok  = 1'b0;
    bus_err = 1'b0;
    ext_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (dec_region == REG_NONE) state_d = S_RESP;
          else if (dec_wait != 4'd0)  state_d = S_WAIT;
          else                        state_d = S_ACCESS;
        end
      end
      S_WAIT: if (cnt_q <= 4'd1) state_d = S_ACCESS;
      S_ACCESS: begin
        ext_req = ~drop_q;
        if (drop_q || bus.ext_ack) state_d = S_RESP;
      end
      S_RESP: begin
        mem_ok  = 1'b1;
        bus_err = (region_q == REG_NONE);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      width_q  <= W_BYTE;
      region_q <= REG_BIOS;
      be_q     <= '0;
      we_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= dec_wait;
        addr_q   <= bus.cpu_addr;
        wdata_q  <= wdata_in;
        rdata_q  <= '0;
        width_q  <= nw;
        region_q <= dec_region;
        be_q     <= be_in;
        we_q     <= we_in;
        drop_q   <= dec_drop;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == S_ACCESS && !drop_q && bus.ext_ack && !we_q) rdata_q <= rd_aligned;
    end
  end

  assign bus.mem_ok     = mem_ok;
  assign bus.bus_err    = bus_err;
  assign bus.ext_req    = ext_req;
  assign bus.ext_we     = we_q;
  assign bus.ext_region = region_q;
  assign bus.ext_addr   = {addr_q[31:2], 2'b00};
  assign bus.ext_be     = be_q;
  assign bus.ext_wdata  = wdata_q;
  assign bus.cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_gba_bus_ctrl.sv
// Scoreboard bench for gba_bus_ctrl: expectations are queued as each request is
// driven and popped when mem_ok pulses.
module tb_gba_bus_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        req;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  region;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  gba_bus_ctrl_if bus();

  gba_bus_ctrl dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_region(input logic [31:0] a);
    return (a[27:24] == 4'h1 || a[27:24] == 4'hF) ? 4'hF : a[27:24];
  endfunction

  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [1:0] width,
                         input logic rd, input logic wr, input logic [31:0] wd,
                         input logic [31:0] ext_val, input int delay,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                         input logic e_req, input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input logic e_we, input bit keep);
    exp_t e, got_e;
    int   cyc, ack_cnt, req_cycles;
    bit   done;
    e.tag = tag;   e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.req = e_req;
    e.be = e_be;   e.wdata = e_wdata; e.we = e_we;   e.addr = {addr[31:2], 2'b00};
    e.region = model_region(addr);
    sb.push_back(e);
    bus.cpu_addr = addr; bus.cpu_width = width; bus.cpu_read = rd;
    bus.cpu_write = wr;  bus.cpu_wdata = wd;
    cyc = 0; ack_cnt = 0; req_cycles = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.ext_req) begin
        if (req_cycles == 0) begin
          check_val({tag, " ext_be"},    32'(bus.ext_be),    32'(e_be));
          check_val({tag, " ext_we"},    32'(bus.ext_we),    32'(e_we));
          check_val({tag, " ext_addr"},  bus.ext_addr,       e.addr);
          if (e_we) check_val({tag, " ext_wdata"}, bus.ext_wdata, e_wdata);
        end
        req_cycles++;
        bus.ext_ack   = (ack_cnt == delay);
        bus.ext_rdata = ext_val;
        ack_cnt++;
      end else begin
        bus.ext_ack = 1'b0;
      end
      if (bus.mem_ok) begin
        done = 1;
        if (sb.size() == 0) begin
          check_val({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
          got_e = sb.pop_front();
          check_val({got_e.tag, " cpu_rdata"},  bus.cpu_rdata,        got_e.rdata);
          check_val({got_e.tag, " bus_err"},    32'(bus.bus_err),     32'(got_e.err));
          check_val({got_e.tag, " latency"},    32'(cyc),             32'(got_e.lat));
          check_val({got_e.tag, " ext_region"}, 32'(bus.ext_region),  32'(got_e.region));
          check_val({got_e.tag, " ext_req seen"}, 32'(req_cycles != 0), 32'(got_e.req));
        end
      end
    end
    if (!done) check_val({tag, " mem_ok timeout"}, 32'(cyc), 32'(e_lat));
    @(posedge clk);
    #1;
    if (!keep) begin
      bus.cpu_read = 1'b0;
      bus.cpu_write = 1'b0;
    end
  endtask

  initial begin
    int extra;
    bit seen;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_width = 2'd0;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.ext_rdata = '0; bus.ext_ack = 1'b0;
    #12;
    check_val("rst mem_ok",    32'(bus.mem_ok),  32'd0);
    check_val("rst ext_req",   32'(bus.ext_req), 32'd0);
    check_val("rst ext_we",    32'(bus.ext_we),  32'd0);
    check_val("rst bus_err",   32'(bus.bus_err), 32'd0);
    check_val("rst ext_be",    32'(bus.ext_be),  32'd0);
    check_val("rst cpu_rdata", bus.cpu_rdata,    32'd0);
    check_val("rst ext_addr",  bus.ext_addr,     32'd0);
    check_val("rst ext_wdata", bus.ext_wdata,    32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    //        tag        addr          w     rd wr wdata         ext_rdata     dly exp_rdata    err lat req be       exp_wdata     we keep
    run_txn("iwram_rd",  32'h0300_0000, 2'd2, 1, 0, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 3, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("ewram_b3",  32'h0200_0003, 2'd0, 1, 0, 32'h0,        32'h11223344, 0, 32'h00000011, 0, 5, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("vram_h2",   32'h0600_0002, 2'd1, 0, 1, 32'h0000ABCD, 32'h0,        0, 32'h0,        0, 3, 1, 4'b1100, 32'hABCDABCD, 1, 0);
    run_txn("oam_bwr",   32'h0700_0000, 2'd0, 0, 1, 32'h00000055, 32'h0,        0, 32'h0,        0, 3, 0, 4'b0000, 32'h0,        1, 0);
    run_txn("pal_bwide", 32'h0500_0001, 2'd0, 0, 1, 32'h00000077, 32'h0,        0, 32'h0,        0, 3, 1, 4'b0011, 32'h77777777, 1, 0);
    run_txn("rom_mis",   32'h0800_0001, 2'd2, 1, 0, 32'h0,        32'h44332211, 0, 32'h11443322, 0, 7, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("rom_wr",    32'h0800_0000, 2'd2, 0, 1, 32'h12345678, 32'h0,        0, 32'h0,        0, 7, 0, 4'b0000, 32'h0,        1, 0);
    run_txn("unmapped",  32'h0F00_0000, 2'd2, 1, 0, 32'h0,        32'h0,        0, 32'h0,        1, 2, 0, 4'b0000, 32'h0,        0, 0);
    run_txn("unmap1_wr", 32'h0100_0000, 2'd2, 0, 1, 32'h1,        32'h0,        0, 32'h0,        1, 2, 0, 4'b0000, 32'h0,        1, 0);
    run_txn("half_a3",   32'h0300_0003, 2'd1, 1, 0, 32'h0,        32'hAABBCCDD, 0, 32'hBB0000AA, 0, 3, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("half_a2",   32'h0300_0002, 2'd1, 1, 0, 32'h0,        32'hAABBCCDD, 0, 32'h0000AABB, 0, 3, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("iw_bwr2",   32'h0300_0002, 2'd0, 0, 1, 32'h00001234, 32'h0,        0, 32'h0,        0, 3, 1, 4'b0100, 32'h34343434, 1, 0);
    run_txn("io_delay",  32'h0400_0000, 2'd2, 1, 0, 32'h0,        32'h12345678, 2, 32'h12345678, 0, 5, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("rd_and_wr", 32'h0300_0000, 2'd2, 1, 1, 32'hFFFFFFFF, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 3, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("w3_word",   32'h0300_0000, 2'd3, 1, 0, 32'h0,        32'h01020304, 0, 32'h01020304, 0, 3, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("sram_brd",  32'h0E00_0001, 2'd0, 1, 0, 32'h0,        32'h000055AA, 0, 32'h00000055, 0, 7, 1, 4'b0000, 32'h0,        0, 0);
    run_txn("sram_wwr",  32'h0E00_0002, 2'd2, 0, 1, 32'h11223344, 32'h0,        0, 32'h0,        0, 7, 1, 4'b0100, 32'h44444444, 1, 0);

    // second request held high through RESP: accepted once, in the cycle after mem_ok
    run_txn("b2b_a",     32'h0300_0000, 2'd2, 1, 0, 32'h0,        32'h0000AAAA, 0, 32'h0000AAAA, 0, 3, 1, 4'b0000, 32'h0,        0, 1);
    run_txn("b2b_b",     32'h0300_0004, 2'd2, 1, 0, 32'h0,        32'h0000BBBB, 0, 32'h0000BBBB, 0, 3, 1, 4'b0000, 32'h0,        0, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_ok) extra++;
    end
    check_val("b2b extra mem_ok", 32'(extra), 32'd0);
    @(posedge clk);
    #1;

    // reset while the backing port is being requested
    bus.cpu_addr = 32'h0800_0000; bus.cpu_width = 2'd2; bus.cpu_read = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.ext_req) seen = 1;
    end
    check_val("rst_mid ext_req reached", 32'(seen), 32'd1);
    rstn = 1'b0;
    #1;
    check_val("rst_mid ext_req", 32'(bus.ext_req), 32'd0);
    check_val("rst_mid mem_ok",  32'(bus.mem_ok),  32'd0);
    bus.cpu_read = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_ok || bus.ext_req) extra++;
    end
    check_val("rst_mid quiet", 32'(extra), 32'd0);
    @(posedge clk);
    #1;
    run_txn("post_rst",  32'h0300_0008, 2'd2, 1, 0, 32'h0,        32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0, 3, 1, 4'b0000, 32'h0,        0, 0);

    check_val("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
